// File: rtl/eth_tx_packer.sv
// eth_tx_packer: cuts a continuous 64-bit beat stream into AXI-Stream frames
// of a programmable beat count. A partial frame is closed by flush or by an
// idle timeout. Beats pass through a pending register P, where the tlast
// decision is made, and then an output register O. Completed frames are counted.
module eth_tx_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 187,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           frame_bytes,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  size_err
);
  localparam int NW = $clog2(MAX_BEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, OPEN} state_t;

  state_t                state;
  logic [NW-1:0]         n_beats;
  logic [NW-1:0]         beat_cnt;
  logic [TW-1:0]         idle_cnt;
  logic                  p_valid, p_last;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  o_valid, o_last;
  logic [DATA_WIDTH-1:0] o_data;

  logic [12:0]   n_raw;
  logic          n_lo, n_hi;
  logic [NW-1:0] n_new, frame_n, next_cnt;
  logic          move_ok, accept, in_last, hold_last, p_last_eff, move;
  logic          unused_bits;

  // Byte-level granularity is dropped; only whole beats count.
  assign unused_bits = ^frame_bytes[2:0];
  assign n_raw       = frame_bytes[15:3];
  assign n_lo        = (n_raw == 13'd0);
  assign n_hi        = (n_raw > 13'(MAX_BEATS));
  assign n_new       = n_lo ? NW'(1) : (n_hi ? NW'(MAX_BEATS) : NW'(n_raw));

  assign move_ok       = !o_valid || m_axis_tready;
  assign s_axis_tready = !rst && (!p_valid || move_ok);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Beat limit and position of the incoming beat: first beat of a frame uses
  // the freshly sampled size, later beats use the size latched at frame start.
  assign frame_n  = (state == IDLE) ? n_new : n_beats;
  assign next_cnt = (state == IDLE) ? NW'(1) : beat_cnt + 1'b1;
  assign in_last  = accept && ((next_cnt == frame_n) || flush);

  // A held, non-last P is closed by flush or by the idle timeout. When O can
  // take it this cycle it moves straight out with tlast set.
  assign hold_last  = p_valid && !p_last && !accept &&
                      (flush || (idle_cnt == TW'(TIMEOUT - 1)));
  assign p_last_eff = p_last || hold_last;
  assign move       = p_valid && move_ok && (accept || p_last_eff);

  assign m_axis_tdata  = o_data;
  assign m_axis_tkeep  = 8'hFF;
  assign m_axis_tvalid = o_valid;
  assign m_axis_tlast  = o_last;

  // Frame state, beat counting and size sampling/clamp reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      n_beats  <= '0;
      beat_cnt <= '0;
      size_err <= 1'b0;
    end else begin
      size_err <= accept && (state == IDLE) && (n_lo || n_hi);
      if (accept) begin
        if (state == IDLE) n_beats <= n_new;
        if (in_last) begin
          state    <= IDLE;
          beat_cnt <= '0;
        end else begin
          state    <= OPEN;
          beat_cnt <= next_cnt;
        end
      end else if (hold_last) begin
        state    <= IDLE;
        beat_cnt <= '0;
      end
    end
  end

  // Pending register P and its idle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid  <= 1'b0;
      p_last   <= 1'b0;
      p_data   <= '0;
      idle_cnt <= '0;
    end else begin
      if (accept) begin
        p_valid <= 1'b1;
        p_last  <= in_last;
        p_data  <= s_axis_tdata;
      end else if (move) begin
        p_valid <= 1'b0;
        p_last  <= 1'b0;
      end else if (hold_last) begin
        p_last  <= 1'b1;
      end

      if (accept || hold_last)
        idle_cnt <= '0;
      else if (p_valid && !p_last)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Output register O and the completed-frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_data    <= '0;
      frame_cnt <= '0;
    end else begin
      if (move) begin
        o_valid <= 1'b1;
        o_last  <= p_last_eff;
        o_data  <= p_data;
      end else if (m_axis_tready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (o_valid && m_axis_tready && o_last)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: doc/eth_tx_packer.md
# eth_tx_packer

Transmit-side framer placed directly upstream of the Ethernet wrapper's `tx_axis_*` input, in the MAC core clock domain (`coreclk`). It takes a continuous 64-bit user data stream and cuts it into AXI-Stream frames of a programmable beat count, driving `tlast`. A partial frame is closed on an explicit flush or after an idle timeout. It also counts completed frames.

## Interface
- `DATA_WIDTH`, 64, stream width in bits; the design is fixed at 64, so `tkeep` is 8 bits.
- `MAX_BEATS`, 187, maximum beats per frame (1496 payload bytes).
- `TIMEOUT`, 256, idle cycles before a held partial frame is closed automatically.
- `CNT_WIDTH`, 32, width of `frame_cnt`.

- `clk`  in  1  core clock; the same clock as MAC `coreclk`.
- `rst`  in  1  synchronous, active-high reset.
- `frame_bytes`  in  16  target frame length in bytes. Bits [2:0] are ignored. Sampled on the first beat of each frame.
- `flush`  in  1  level-sampled each cycle; closes the open frame.
- `s_axis_tdata`  in  64  user data; all 8 bytes of every beat are valid.
- `s_axis_tvalid`  in  1  user beat valid.
- `s_axis_tready`  out  1  packer can accept a beat.
- `m_axis_tdata`  out  64  frame data.
- `m_axis_tkeep`  out  8  constant 8'hFF.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tlast`  out  1  last beat of frame.
- `m_axis_tready`  in  1  downstream ready.
- `frame_cnt`  out  CNT_WIDTH  frames completed; wraps modulo 2^CNT_WIDTH.
- `size_err`  out  1  one-cycle pulse when the sampled size was clamped.

## Operation
- **Frame state.** Two states: IDLE (no open frame) and OPEN. A beat accepted in IDLE starts a frame:
  - sample N = `frame_bytes[15:3]`;
  - if N = 0, set N = 1; if N > `MAX_BEATS`, set N = `MAX_BEATS`;
  - on either clamp, pulse `size_err` in the cycle after acceptance;
  - `beat_cnt` is set to 1.
- **Pending register P.** Every accepted beat enters a one-beat pending register P. The beat's `last` flag is decided while it sits in P.
- **P is marked last when any of these occur:**
  - the accepted beat makes `beat_cnt` equal N;
  - `flush` = 1 in the cycle the beat is accepted;
  - `flush` = 1 while P is valid and not last;
  - the idle counter reaches `TIMEOUT`.
- **Leaving OPEN.** When P is marked last, `beat_cnt` clears and the state returns to IDLE. The next accepted beat starts a new frame and resamples `frame_bytes`.
- **Moving P to output register O.**
  - Define move_ok = !O_valid || `m_axis_tready`.
  - P moves to O when move_ok holds and either P is last, or a new beat is accepted that cycle. A non-last P moves with tlast = 0.
- **Input ready.** `s_axis_tready` = !P_valid || move_ok. It is 0 while `rst` is high.
- **Idle counter.** It increments on each cycle where P is valid, P is not last, and no beat is accepted. It clears on any accepted beat and whenever P is marked last.
- **Flush with nothing held.** When P is empty and no beat is accepted, `flush` is ignored; zero-length frames are never produced.
- **Output.** O holds a beat stable until `m_axis_tvalid` && `m_axis_tready`.
- **Frame count.** `frame_cnt` increments on each handshake where `m_axis_tlast` = 1.
- **Mid-frame `frame_bytes` changes** have no effect until the next frame starts.

## Timing
- **Reset.** While `rst` is high: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `frame_cnt`=0, `size_err`=0, `s_axis_tready`=0, `m_axis_tkeep`=8'hFF. State goes to IDLE and P, O and all counters clear. Reset mid-frame discards P and O; the partial frame is lost and no tlast is emitted.
- **Latency.** A beat accepted at cycle t is in P at t+1.
  - It appears on `m_axis` at t+2 at the earliest: when the next beat is accepted at t+1, or when it was marked last at acceptance.
  - A held partial beat appears 1 cycle after it is marked last, given move_ok.
- **Throughput.** With `m_axis_tready` held at 1, the packer sustains 1 beat per cycle with no bubble at frame boundaries.
- **Backpressure.** With O full and `m_axis_tready`=0, P stays valid and `s_axis_tready` drops the same cycle (combinational). No beat is lost, duplicated or reordered.

## Test plan
- `frame_bytes`=64, `TIMEOUT`=16, 20 back-to-back beats with data 0..19, `m_axis_tready`=1:
  - expect frames {0..7} and {8..15} with tlast on beats 7 and 15;
  - beats 16..18 appear as they are pushed out, beat 19 is held;
  - 16 idle cycles later beat 19 emits with tlast=1;
  - `frame_cnt`=3.
- `frame_bytes`=64, 3 beats, then `flush` pulse:
  - expect a 3-beat frame, tlast on the third beat, 1 cycle after the flush;
  - a `flush` with no data held produces no output.
- `frame_bytes`=3:
  - every beat has tlast=1 and `size_err` pulses per frame.
  - Then `frame_bytes`=16'hFFFF: 187-beat frames and `size_err` pulses.
- Random 50% `m_axis_tready`, 1000 beats, `frame_bytes`=128:
  - output order equals input order;
  - every 16th beat has tlast;
  - the data stays stable while stalled.
- `frame_bytes` changed 64→32 at beat 3 of a frame: the current frame stays 8 beats and the following frames are 4 beats.
- `rst` asserted for one cycle at beat 5 of an 8-beat frame:
  - outputs take their reset values;
  - the next accepted beat starts a fresh full frame;
  - `frame_cnt` restarts at 0.
